// File: rtl/ep_cmpl_queue_if.sv
// ep_cmpl_queue_if: push, command-done, TX request and status signals of the completion queue.
interface ep_cmpl_queue_if #(
    parameter int DEPTH   = 8,
    parameter int NUM_IDS = 4
);
    localparam int ID_W  = $clog2(NUM_IDS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic             push_i;
    logic             push_with_data_i;
    logic [ID_W-1:0]  push_id_i;
    logic [2:0]       req_tc_i;
    logic             req_td_i;
    logic             req_ep_i;
    logic [1:0]       req_attr_i;
    logic [9:0]       req_len_i;
    logic [15:0]      req_rid_i;
    logic [7:0]       req_tag_i;
    logic [7:0]       req_be_i;
    logic [12:0]      req_addr_i;
    logic             cmd_compl_i;
    logic [ID_W-1:0]  cmd_id_i;
    logic             req_compl_o;
    logic             req_compl_with_data_o;
    logic [2:0]       req_tc_o;
    logic             req_td_o;
    logic             req_ep_o;
    logic [1:0]       req_attr_o;
    logic [9:0]       req_len_o;
    logic [15:0]      req_rid_o;
    logic [7:0]       req_tag_o;
    logic [7:0]       req_be_o;
    logic [12:0]      req_addr_o;
    logic             compl_done_i;
    logic             rx_np_ok_o;
    logic             full_o;
    logic [CNT_W-1:0] level_o;
    logic             overflow_o;
    modport master (
        output push_i, push_with_data_i, push_id_i, req_tc_i, req_td_i, req_ep_i, req_attr_i,
               req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i, cmd_compl_i, cmd_id_i,
               compl_done_i,
        input  req_compl_o, req_compl_with_data_o, req_tc_o, req_td_o, req_ep_o, req_attr_o,
               req_len_o, req_rid_o, req_tag_o, req_be_o, req_addr_o, rx_np_ok_o, full_o,
               level_o, overflow_o
    );
    modport slave (
        input  push_i, push_with_data_i, push_id_i, req_tc_i, req_td_i, req_ep_i, req_attr_i,
               req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i, cmd_compl_i, cmd_id_i,
               compl_done_i,
        output req_compl_o, req_compl_with_data_o, req_tc_o, req_td_o, req_ep_o, req_attr_o,
               req_len_o, req_rid_o, req_tag_o, req_be_o, req_addr_o, rx_np_ok_o, full_o,
               level_o, overflow_o
    );
endinterface

// File: rtl/ep_cmpl_queue.sv
// ep_cmpl_queue: in-order completion queue from RX to TX engine with NP throttling.
// Define EP_CMPL_QUEUE_CMD_WAIT_EN to hold each entry until its command ID reports done.
module ep_cmpl_queue #(
    parameter int DEPTH     = 8,
    parameter int NUM_IDS   = 4,
    parameter int NP_THRESH = 6
) (
    input logic            clk,
    input logic            rst,
    ep_cmpl_queue_if.slave q
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef EP_CMPL_QUEUE_CMD_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
`else
    typedef enum logic {IDLE, ISSUE} state_t;
`endif
    state_t           state;
    logic [62:0]      mem [DEPTH];
    logic [62:0]      hdr;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             req, ovf, pop, push_ok, go;
    assign pop     = (state == ISSUE) && q.compl_done_i;
    assign push_ok = q.push_i && (cnt != CNT_W'(DEPTH) || pop);
    always_ff @(posedge clk)
        if (push_ok)
            mem[wr_ptr] <= {q.push_with_data_i, q.req_tc_i, q.req_td_i, q.req_ep_i, q.req_attr_i,
                            q.req_len_i, q.req_rid_i, q.req_tag_i, q.req_be_i, q.req_addr_i};
`ifdef EP_CMPL_QUEUE_CMD_WAIT_EN
    localparam int ID_W = $clog2(NUM_IDS);
    logic [ID_W-1:0]    ids [DEPTH];
    logic [NUM_IDS-1:0] rdy;
    always_ff @(posedge clk)
        if (push_ok) ids[wr_ptr] <= q.push_id_i;
    // a done pulse landing on the popping ID belongs to a later command, so set beats clear
    always_ff @(posedge clk or posedge rst)
        if (rst) rdy <= '0;
        else
            for (int i = 0; i < NUM_IDS; i++)
                if (q.cmd_compl_i && q.cmd_id_i == ID_W'(i)) rdy[i] <= 1'b1;
                else if (pop && ids[rd_ptr] == ID_W'(i)) rdy[i] <= 1'b0;
    assign go = rdy[ids[rd_ptr]];
`else
    logic unused_cmd;
    assign unused_cmd = ^{q.cmd_compl_i, q.cmd_id_i, q.push_id_i};
    assign go = 1'b1;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt    <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
            ovf    <= ovf | (q.push_i & ~push_ok);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            req   <= 1'b0;
            hdr   <= '0;
        end else
            case (state)
                ISSUE:
                    if (q.compl_done_i) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end
                default:
                    if (cnt != '0) begin
                        if (go) begin
                            state <= ISSUE;
                            req   <= 1'b1;
                            hdr   <= mem[rd_ptr];
                        end
`ifdef EP_CMPL_QUEUE_CMD_WAIT_EN
                        else state <= WAIT;
`endif
                    end
            endcase
    assign q.req_compl_o = req;
    assign {q.req_compl_with_data_o, q.req_tc_o, q.req_td_o, q.req_ep_o, q.req_attr_o,
            q.req_len_o, q.req_rid_o, q.req_tag_o, q.req_be_o, q.req_addr_o} = hdr;
    assign q.level_o    = cnt;
    assign q.full_o     = cnt == CNT_W'(DEPTH);
    assign q.rx_np_ok_o = cnt < CNT_W'(NP_THRESH);
    assign q.overflow_o = ovf;
endmodule

// File: tb/tb_ep_cmpl_queue.sv
// tb_ep_cmpl_queue: directed boundary cases plus random traffic against a queue-level reference model.
module tb_ep_cmpl_queue;
    localparam int DEPTH = 8, NUM_IDS = 4, NP_THRESH = 6, ID_W = 2;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    ep_cmpl_queue_if #(.DEPTH(DEPTH), .NUM_IDS(NUM_IDS)) bus ();
    ep_cmpl_queue #(.DEPTH(DEPTH), .NUM_IDS(NUM_IDS), .NP_THRESH(NP_THRESH)) dut (
        .clk(clk), .rst(rst), .q(bus)
    );
    int tests = 0, fails = 0;
    logic [62:0]        mq[$];
    logic [ID_W-1:0]    mid[$];
    logic               m_iss = 1'b0, m_ovf = 1'b0;
    logic [NUM_IDS-1:0] m_rdy = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic head_ready();
`ifdef EP_CMPL_QUEUE_CMD_WAIT_EN
        return m_rdy[mid[0]];
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive(input logic p, input logic [62:0] h, input logic [ID_W-1:0] pid,
                         input logic c, input logic [ID_W-1:0] cid, input logic d);
        bus.push_i = p;
        {bus.push_with_data_i, bus.req_tc_i, bus.req_td_i, bus.req_ep_i, bus.req_attr_i,
         bus.req_len_i, bus.req_rid_i, bus.req_tag_i, bus.req_be_i, bus.req_addr_i} = h;
        bus.push_id_i    = pid;
        bus.cmd_compl_i  = c;
        bus.cmd_id_i     = cid;
        bus.compl_done_i = d;
    endtask

    // one clock: check outputs against the model, apply inputs, advance the model
    task automatic cycle(input logic p, input logic [ID_W-1:0] pid, input logic c,
                         input logic [ID_W-1:0] cid, input logic d);
        logic [62:0] h;
        logic        pop, acc, nxt;
        h = 63'({$urandom(), $urandom()});
        @(negedge clk);
        check("level", 64'(bus.level_o), 64'(mq.size()));
        check("full", 64'(bus.full_o), 64'(mq.size() == DEPTH));
        check("np_ok", 64'(bus.rx_np_ok_o), 64'(mq.size() < NP_THRESH));
        check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
        check("req_compl", 64'(bus.req_compl_o), 64'(m_iss));
        if (m_iss)
            check("hdr", 64'({bus.req_compl_with_data_o, bus.req_tc_o, bus.req_td_o, bus.req_ep_o,
                              bus.req_attr_o, bus.req_len_o, bus.req_rid_o, bus.req_tag_o,
                              bus.req_be_o, bus.req_addr_o}), 64'(mq[0]));
        drive(p, h, pid, c, cid, d);
        pop = m_iss && d;
        acc = p && (mq.size() < DEPTH || pop);
        nxt = m_iss ? !d : (mq.size() != 0 && head_ready());
        if (pop) begin
            m_rdy[mid[0]] = 1'b0;
            void'(mq.pop_front());
            void'(mid.pop_front());
        end
        if (c) m_rdy[cid] = 1'b1;
        if (acc) begin
            mq.push_back(h);
            mid.push_back(pid);
        end else if (p) m_ovf = 1'b1;
        m_iss = nxt;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check("rst_async_req", 64'(bus.req_compl_o), 64'(0));
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        mq.delete();
        mid.delete();
        m_iss = 1'b0;
        m_ovf = 1'b0;
        m_rdy = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // fill to full, then push and finish together at the full boundary, then overflow
        cycle(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        repeat (8) cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(2);
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        idle(2);
        do_reset();
        // NP threshold: six pushes, then one completion
        repeat (6) cycle(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        idle(1);
        cycle(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        idle(2);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(2);
        do_reset();
        // reset while issuing with three entries queued
        repeat (3) cycle(1'b1, 2'd3, 1'b1, 2'd3, 1'b0);
        idle(3);
        do_reset();
        idle(1);
        // out-of-order command completions must not reorder issue
        cycle(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        idle(4);
        cycle(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        idle(3);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(3);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(3);
        // ready pulse for ID 0 in the same cycle the ID-0 head pops
        cycle(1'b1, 2'd0, 1'b1, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        idle(3);
        cycle(1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
        idle(3);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(2);
        for (int k = 0; k < 2; k++) begin
            repeat (2000)
                cycle(1'($urandom_range(0, 1)), ID_W'($urandom()), $urandom_range(0, 3) == 0,
                      ID_W'($urandom()), $urandom_range(0, 2) == 0);
            idle(4);
            do_reset();
        end
        idle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ep_cmpl_queue.md
# ep_cmpl_queue

Parametrised completion-request queue between the RX engine and the TX engine of the PCIe endpoint. Buffers up to DEPTH completion headers, optionally holds each one until its backing command reports done via `cmd_compl_i`, and issues them in order to the TX engine with a level handshake. It also throttles non-posted reception through `rx_np_ok_o` using a programmable threshold.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, 4..64.
- `NUM_IDS`, 4: distinct command IDs, 2..16.
- `NP_THRESH`, 6: `rx_np_ok_o` drops when occupancy reaches this value; 1..DEPTH.
- Derived: `ID_W = clog2(NUM_IDS)`, `CNT_W = clog2(DEPTH)+1`.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `push_i`  in  1  enqueue one header this cycle.
- `push_with_data_i`  in  1  the header is CplD (1) or Cpl (0).
- `push_id_i`  in  ID_W  command ID this completion waits on.
- `req_tc_i`/`req_td_i`/`req_ep_i`/`req_attr_i`/`req_len_i`/`req_rid_i`/`req_tag_i`/`req_be_i`/`req_addr_i`  in  3/1/1/2/10/16/8/8/13  header fields.
- `cmd_compl_i`  in  1  one-cycle pulse: command `cmd_id_i` finished.
- `cmd_id_i`  in  ID_W  ID qualified by `cmd_compl_i`.
- `req_compl_o`  out  1  completion request to the TX engine, level.
- `req_compl_with_data_o`  out  1  CplD flag of the head entry.
- `req_*_o`  out  same widths as the inputs  head-entry header fields.
- `compl_done_i`  in  1  one-cycle pulse from the TX engine: completion sent.
- `rx_np_ok_o`  out  1  occupancy < NP_THRESH.
- `full_o`  out  1  occupancy == DEPTH.
- `level_o`  out  CNT_W  current occupancy.
- `overflow_o`  out  1  sticky: a push was dropped.

## Operation
- Storage: circular buffer of DEPTH entries, 63 bits each (62 header bits plus the CplD flag) plus ID_W bits for the ID. Read and write pointers are `clog2(DEPTH)` bits and wrap naturally.
- Push acceptance:
  - A push is accepted when `full_o==0`, or when a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow_o` sets; it clears only on reset.
- Ready bitmap `rdy[NUM_IDS-1:0]`:
  - `cmd_compl_i` sets `rdy[cmd_id_i]`.
  - A pop clears `rdy[head_id]`.
  - If a set and a clear hit the same ID in the same cycle, the set wins (the pulse belongs to a later command).
- FSM states:
  - IDLE: if the queue is non-empty, go to ISSUE when `rdy[head_id]` is set, else go to WAIT.
  - WAIT: go to ISSUE once `rdy[head_id]` is set.
  - ISSUE: `req_compl_o` = 1. On `compl_done_i`, pop and go to IDLE.
- `compl_done_i` outside ISSUE is ignored.
- Header outputs are registered copies of the head entry. They are loaded on the IDLE→ISSUE or WAIT→ISSUE transition and stay stable throughout ISSUE.
- Level arithmetic: a simultaneous accepted push and pop leaves `level_o` unchanged. A pop is impossible when empty; `level_o` never exceeds DEPTH.

## Timing
- Reset values:
  - `req_compl_o`=0, `req_compl_with_data_o`=0, all `req_*_o`=0.
  - `rx_np_ok_o`=1, `full_o`=0, `level_o`=0, `overflow_o`=0.
  - `rdy`=0, pointers=0, state=IDLE.
- Assertion of `rst` takes effect immediately, including mid-ISSUE: `req_compl_o` drops asynchronously and queued entries are discarded.
- A push in cycle N shows in `level_o`, `full_o` and `rx_np_ok_o` at N+1; these three are decoded from the registered count.
- Empty queue, ready ID, push at N: `req_compl_o` rises at N+2.
- `compl_done_i` at M: `req_compl_o` falls at M+1. The next ready entry raises `req_compl_o` at M+2, giving one idle cycle minimum between completions.
- A `cmd_compl_i` at K for the head ID while in WAIT: `req_compl_o` rises at K+2.

## Configuration
- Macro: `EP_CMPL_QUEUE_CMD_WAIT_EN`.
- Defined: the ready-bitmap gating described above applies.
- Undefined:
  - The `rdy` logic and the WAIT state are not built.
  - `cmd_compl_i`/`cmd_id_i` are ignored.
  - IDLE goes to ISSUE whenever the queue is non-empty.

## Test plan
- Reset mid-ISSUE with 3 entries queued -> `req_compl_o`=0 immediately; `level_o`=0, `rx_np_ok_o`=1 after release.
- DEPTH=8, 9 pushes with no pops -> `full_o`=1 after the 8th; the 9th is dropped, `overflow_o`=1, `level_o`=8.
- NP_THRESH=6, 6 pushes -> `rx_np_ok_o` falls the cycle after the 6th push; one completion -> it rises again.
- Push IDs 2,1 with `cmd_compl` on ID 1 first -> nothing is issued until `cmd_compl` on ID 2; the completions then issue in order, tag of ID 2 first.
- Full queue, push and `compl_done_i` in the same cycle -> push accepted, `level_o` stays 8, `overflow_o` stays 0.
- `cmd_compl` on ID 0 in the same cycle the head with ID 0 pops, next entry also ID 0 -> the next entry issues without waiting.
